// File: rtl/kalman_state_engine.sv
// Fixed-point Kalman state engine: prediction x_pred = A*x_upd + B*U and
// update innov = Y - C*x_pred, x_upd = x_pred + K*innov on one shared MAC.
module kalman_state_engine #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int NOS   = 4,
  parameter int NOO   = 2,
  parameter int NOI   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clk_en,
  input  logic                                 start_pred,
  input  logic                                 start_upd,
  input  logic                                 chain,
  input  logic                                 load_x0,
  input  logic [NOS-1:0][WIDTH-1:0]            x0,
  input  logic [NOS-1:0][NOS-1:0][WIDTH-1:0]   a,
  input  logic [NOS-1:0][NOI-1:0][WIDTH-1:0]   b,
  input  logic [NOO-1:0][NOS-1:0][WIDTH-1:0]   c,
  input  logic [NOS-1:0][NOO-1:0][WIDTH-1:0]   k,
  input  logic [NOI-1:0][WIDTH-1:0]            u,
  input  logic [NOO-1:0][WIDTH-1:0]            y,
  output logic                                 busy,
  output logic                                 done_pred,
  output logic                                 done_upd,
  output logic [NOS-1:0][WIDTH-1:0]            x_pred,
  output logic [NOS-1:0][WIDTH-1:0]            x_upd,
  output logic [NOO-1:0][WIDTH-1:0]            innov,
  output logic                                 sat_flag
);

  localparam int AW   = 2 * WIDTH + 4;
  localparam int MAXC = (NOS + NOI > NOO) ? NOS + NOI : NOO;
  localparam int MAXR = (NOS > NOO) ? NOS : NOO;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int RW   = $clog2(MAXR + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRED_MAC  = 3'd1;
  localparam logic [2:0] PRED_WB   = 3'd2;
  localparam logic [2:0] INNOV_MAC = 3'd3;
  localparam logic [2:0] INNOV_WB  = 3'd4;
  localparam logic [2:0] UPD_MAC   = 3'd5;
  localparam logic [2:0] UPD_WB    = 3'd6;

  localparam logic signed [AW-1:0] MAXV = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic [2:0]                  state;
  logic [RW-1:0]               row;
  logic [CW-1:0]               col;
  logic signed [AW-1:0]        acc;
  logic                        chain_r;
  logic [NOS-1:0][WIDTH-1:0]   xp_w;
  logic [NOS-1:0][WIDTH-1:0]   xu_w;
  logic [NOO-1:0][WIDTH-1:0]   in_w;

  logic signed [WIDTH-1:0]     op_a;
  logic signed [WIDTH-1:0]     op_b;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [AW-1:0]        prod_ext;
  logic signed [AW-1:0]        preload;
  logic signed [AW-1:0]        base;
  logic signed [AW-1:0]        acc_next;
  logic signed [AW-1:0]        shifted;
  logic                        sub;
  logic                        last_col;
  logic                        last_row;
  logic [WIDTH-1:0]            wb_val;
  logic                        clip;
  logic [NOS-1:0][WIDTH-1:0]   xp_commit;
  logic [NOS-1:0][WIDTH-1:0]   xu_commit;
  logic [NOO-1:0][WIDTH-1:0]   in_commit;

  assign busy = (state != IDLE);

  // Operand selection: row/col are decoded by loops so that every index is a constant.
  always_comb begin
    op_a     = '0;
    op_b     = '0;
    sub      = 1'b0;
    preload  = '0;
    last_col = 1'b0;
    last_row = 1'b0;
    case (state)
      PRED_MAC: begin
        last_col = (col == CW'(NOS + NOI - 1));
        for (int unsigned i = 0; i < NOS; i++) begin
          if (row == RW'(i)) begin
            for (int unsigned j = 0; j < NOS; j++) begin
              if (col == CW'(j)) begin
                op_a = a[i][j];
                op_b = x_upd[j];
              end
            end
            for (int unsigned j = 0; j < NOI; j++) begin
              if (col == CW'(NOS + j)) begin
                op_a = b[i][j];
                op_b = u[j];
              end
            end
          end
        end
      end
      INNOV_MAC: begin
        sub      = 1'b1;
        last_col = (col == CW'(NOS - 1));
        for (int unsigned j = 0; j < NOO; j++) begin
          if (row == RW'(j)) begin
            preload = {{(AW-WIDTH){y[j][WIDTH-1]}}, y[j]} <<< FRAC;
            for (int unsigned i = 0; i < NOS; i++) begin
              if (col == CW'(i)) begin
                op_a = c[j][i];
                op_b = xp_w[i];
              end
            end
          end
        end
      end
      UPD_MAC: begin
        last_col = (col == CW'(NOO - 1));
        for (int unsigned i = 0; i < NOS; i++) begin
          if (row == RW'(i)) begin
            preload = {{(AW-WIDTH){xp_w[i][WIDTH-1]}}, xp_w[i]} <<< FRAC;
            for (int unsigned j = 0; j < NOO; j++) begin
              if (col == CW'(j)) begin
                op_a = k[i][j];
                op_b = in_w[j];
              end
            end
          end
        end
      end
      PRED_WB:  last_row = (row == RW'(NOS - 1));
      INNOV_WB: last_row = (row == RW'(NOO - 1));
      UPD_WB:   last_row = (row == RW'(NOS - 1));
      default: ;
    endcase
  end

  // First MAC of a row starts from the additive preload instead of the old accumulator.
  always_comb begin
    prod     = op_a * op_b;
    prod_ext = {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    base     = (col == '0) ? preload : acc;
    acc_next = sub ? (base - prod_ext) : (base + prod_ext);
    shifted  = acc >>> FRAC;
    clip     = 1'b0;
    if (shifted > MAXV) begin
      wb_val = MAXV[WIDTH-1:0];
      clip   = 1'b1;
    end else if (shifted < MINV) begin
      wb_val = MINV[WIDTH-1:0];
      clip   = 1'b1;
    end else begin
      wb_val = shifted[WIDTH-1:0];
    end
  end

  // Working vectors with the row being written back merged in, for same-edge commit.
  always_comb begin
    xp_commit = xp_w;
    xu_commit = xu_w;
    in_commit = in_w;
    for (int unsigned i = 0; i < NOS; i++) begin
      if (row == RW'(i)) begin
        if (state == PRED_WB) xp_commit[i] = wb_val;
        if (state == UPD_WB)  xu_commit[i] = wb_val;
      end
    end
    for (int unsigned j = 0; j < NOO; j++) begin
      if (row == RW'(j) && state == INNOV_WB) in_commit[j] = wb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      acc       <= '0;
      chain_r   <= 1'b0;
      xp_w      <= '0;
      xu_w      <= '0;
      in_w      <= '0;
      x_pred    <= '0;
      x_upd     <= '0;
      innov     <= '0;
      sat_flag  <= 1'b0;
      done_pred <= 1'b0;
      done_upd  <= 1'b0;
    end else if (clk_en) begin
      done_pred <= 1'b0;
      done_upd  <= 1'b0;
      case (state)
        IDLE: begin
          row <= '0;
          col <= '0;
          if (start_pred) begin
            state   <= PRED_MAC;
            chain_r <= chain;
          end else if (start_upd) begin
            state   <= INNOV_MAC;
            chain_r <= 1'b0;
          end else if (load_x0) begin
            x_pred   <= x0;
            x_upd    <= x0;
            xp_w     <= x0;
            xu_w     <= x0;
            sat_flag <= 1'b0;
          end
        end
        PRED_MAC, INNOV_MAC, UPD_MAC: begin
          acc <= acc_next;
          if (last_col) begin
            col <= '0;
            case (state)
              PRED_MAC:  state <= PRED_WB;
              INNOV_MAC: state <= INNOV_WB;
              default:   state <= UPD_WB;
            endcase
          end else begin
            col <= col + CW'(1);
          end
        end
        PRED_WB: begin
          xp_w     <= xp_commit;
          sat_flag <= sat_flag | clip;
          if (last_row) begin
            row       <= '0;
            x_pred    <= xp_commit;
            done_pred <= 1'b1;
            state     <= chain_r ? INNOV_MAC : IDLE;
          end else begin
            row   <= row + RW'(1);
            state <= PRED_MAC;
          end
        end
        INNOV_WB: begin
          in_w     <= in_commit;
          sat_flag <= sat_flag | clip;
          if (last_row) begin
            row   <= '0;
            state <= UPD_MAC;
          end else begin
            row   <= row + RW'(1);
            state <= INNOV_MAC;
          end
        end
        UPD_WB: begin
          xu_w     <= xu_commit;
          sat_flag <= sat_flag | clip;
          if (last_row) begin
            row      <= '0;
            x_upd    <= xu_commit;
            innov    <= in_w;
            done_upd <= 1'b1;
            chain_r  <= 1'b0;
            state    <= IDLE;
          end else begin
            row   <= row + RW'(1);
            state <= UPD_MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
